pwm_multi_ch: RTL and testbench
===============================

PWM_MULTI_CH -- requirements
Module: pwm_multi_ch

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, the bit width of the counter, period and each duty value.
REQ-002 SHALL provide parameter CHANNELS, default 4, the number of independent PWM outputs.
REQ-003 SHALL provide parameter PRESCALE_W, default 12, the bit width of the prescaler.
REQ-004 SHALL have port CLK_100MHz, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port EN, input, 1 bit: run enable.
REQ-007 SHALL have port PRESCALE, input, PRESCALE_W bits, live (not shadowed): a counter tick occurs every PRESCALE+1 clocks.
REQ-008 SHALL have port PERIOD, input, WIDTH bits, shadowed: the counter top value.
REQ-009 SHALL have port CENTER, input, 1 bit, shadowed: 0 = edge-aligned, 1 = center-aligned.
REQ-010 SHALL have port DUTY, input, CHANNELS*WIDTH bits, shadowed: channel i compare value is at bits [i*WIDTH +: WIDTH].
REQ-011 SHALL have port LOAD_REQ, input, 1 bit: request to capture PERIOD, CENTER and DUTY.
REQ-012 SHALL have port LOAD_ACK, output, 1 bit: one-clock pulse when the active registers update.
REQ-013 SHALL have port E, output, 1 bit: one-clock pulse at each period boundary.
REQ-014 SHALL have port TCR, output, WIDTH bits: the current counter value.
REQ-015 SHALL have port PWM_OUT, output, CHANNELS bits: registered PWM outputs.

Function
REQ-016 SHALL, while EN=1, count the prescaler 0..PRESCALE and produce a tick on the clock where it equals PRESCALE, then restart at 0; PRESCALE=0 ticks every clock.
REQ-017 SHALL, in edge mode, advance TCR by 1 on each tick and wrap from active PERIOD to 0.
REQ-018 SHALL, in center mode, count TCR up to PERIOD, then down to 0, then up again; direction reverses at PERIOD and at 0; period length is 2*PERIOD ticks.
REQ-019 SHALL define the boundary as the tick that loads TCR=0 (edge: PERIOD->0; center: 1->0); SHALL assert E for exactly the clock in which TCR first reads 0.
REQ-020 SHALL, with active PERIOD=0 in either mode, hold TCR at 0 and treat every tick as a boundary.
REQ-021 SHALL register PWM_OUT[i] = (TCR < active_duty[i]), one clock after TCR updates.
REQ-022 SHALL hold PWM_OUT[i] constantly 0 when duty=0, and constantly 1 when duty>PERIOD; the compare is unsigned and full WIDTH.
REQ-023 SHALL, on a clock with LOAD_REQ=1, capture DUTY, PERIOD and CENTER into pending registers and set the pending flag; a later request overwrites the pending values.
REQ-024 SHALL, with EN=1, transfer pending to active at the next boundary and assert LOAD_ACK coincident with E.
REQ-025 SHALL, if LOAD_REQ coincides with a boundary, have the boundary apply any previously pending set and hold the newly captured set until the following boundary.
REQ-026 SHALL, with EN=0, transfer pending to active on the clock after capture and pulse LOAD_ACK, two clocks after LOAD_REQ is sampled.
REQ-027 SHALL, with EN=0, hold TCR, the prescaler and the direction; E=0; PWM_OUT registered to 0.
REQ-028 SHALL, when EN goes 0->1, resume from the held TCR value and direction.
REQ-029 SHALL, when CENTER changes at a boundary, restart counting upward from 0.

Reset
REQ-030 SHALL, on a clock with RST=1, clear TCR, prescaler, active and pending registers and pending flag, set direction to up, and drive PWM_OUT, E and LOAD_ACK to 0; RST overrides EN and LOAD_REQ.
REQ-031 SHALL discard a pending load on reset mid-period; no LOAD_ACK follows.

Verification
REQ-032 SHALL cover: WIDTH=8, CHANNELS=4, PRESCALE=0, PERIOD=9, edge, DUTY0=3, loaded with EN=0, then EN=1 -> LOAD_ACK two clocks after LOAD_REQ; PWM_OUT[0] high 3 of every 10 clocks; E every 10 clocks.
REQ-033 SHALL cover: DUTY1=0, DUTY2=10, DUTY3=255 with PERIOD=9 -> PWM_OUT[1] always 0; PWM_OUT[2] and PWM_OUT[3] always 1.
REQ-034 SHALL cover: running with DUTY0=3, then load DUTY0=7 at TCR=4 -> high time stays 3 until the wrap; LOAD_ACK coincides with E; next period high time is 7.
REQ-035 SHALL cover: center mode, PERIOD=4, DUTY0=2 -> TCR sequence 0,1,2,3,4,3,2,1 repeating; PWM_OUT[0] high 3 of every 8 clocks; E every 8 clocks.
REQ-036 SHALL cover: PRESCALE=3, PERIOD=9, edge -> TCR steps every 4 clocks; E every 40 clocks.
REQ-037 SHALL cover: RST asserted one clock after LOAD_REQ while running -> all outputs 0 on the next clock, TCR=0, and no LOAD_ACK afterward.

Source files
------------

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: shared prescaled timebase (edge or center aligned)
// with shadowed period/mode/duty registers that update at period boundaries.

module pwm_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] tcr,
    input  logic [WIDTH-1:0] duty,
    output logic             pwm
);
    always_ff @(posedge clk) begin
        if (rst) pwm <= 1'b0;
        else     pwm <= en && (tcr < duty);
    end
endmodule

module pwm_multi_ch #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 12
) (
    input  logic                      CLK_100MHz,
    input  logic                      RST,
    input  logic                      EN,
    input  logic [PRESCALE_W-1:0]     PRESCALE,
    input  logic [WIDTH-1:0]          PERIOD,
    input  logic                      CENTER,
    input  logic [CHANNELS*WIDTH-1:0] DUTY,
    input  logic                      LOAD_REQ,
    output logic                      LOAD_ACK,
    output logic                      E,
    output logic [WIDTH-1:0]          TCR,
    output logic [CHANNELS-1:0]       PWM_OUT
);
    logic [PRESCALE_W-1:0]          psc;
    logic [WIDTH-1:0]               tcr;
    logic                           down;
    logic [WIDTH-1:0]               act_period, pend_period;
    logic                           act_center, pend_center;
    logic [CHANNELS-1:0][WIDTH-1:0] act_duty, pend_duty;
    logic                           pend_flag;
    logic                           e, load_ack;

    logic             tick, boundary, apply;
    logic [WIDTH-1:0] tcr_nxt;
    logic             down_nxt;

    assign tick = EN && (psc >= PRESCALE);

    always_comb begin
        tcr_nxt  = tcr;
        down_nxt = down;
        if (!act_center) begin
            down_nxt = 1'b0;
            tcr_nxt  = (tcr >= act_period) ? '0 : tcr + 1'b1;
        end else if (act_period == '0) begin
            tcr_nxt  = '0;
            down_nxt = 1'b0;
        end else if (!down && (tcr < act_period)) begin
            tcr_nxt  = tcr + 1'b1;
            down_nxt = 1'b0;
        end else begin
            // Falling side; direction flips back to up as soon as 0 is reached.
            tcr_nxt  = (tcr == '0) ? '0 : tcr - 1'b1;
            down_nxt = (tcr > WIDTH'(1));
        end
    end

    assign boundary = tick && (tcr_nxt == '0);
    // Stopped: pending set goes live the clock after capture instead of waiting.
    assign apply    = pend_flag && (EN ? boundary : 1'b1);

    always_ff @(posedge CLK_100MHz) begin
        if (RST) begin
            psc         <= '0;
            tcr         <= '0;
            down        <= 1'b0;
            act_period  <= '0;
            act_center  <= 1'b0;
            act_duty    <= '0;
            pend_period <= '0;
            pend_center <= 1'b0;
            pend_duty   <= '0;
            pend_flag   <= 1'b0;
            e           <= 1'b0;
            load_ack    <= 1'b0;
        end else begin
            e        <= boundary;
            load_ack <= apply;
            if (EN) psc <= tick ? '0 : psc + 1'b1;
            if (tick) begin
                tcr  <= tcr_nxt;
                down <= down_nxt;
            end
            if (apply) begin
                act_period <= pend_period;
                act_center <= pend_center;
                act_duty   <= pend_duty;
                pend_flag  <= 1'b0;
            end
            // A request on the applying clock stays pending for the next boundary.
            if (LOAD_REQ) begin
                pend_period <= PERIOD;
                pend_center <= CENTER;
                pend_duty   <= DUTY;
                pend_flag   <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        pwm_lane #(.WIDTH(WIDTH)) u_lane (
            .clk  (CLK_100MHz),
            .rst  (RST),
            .en   (EN),
            .tcr  (tcr),
            .duty (act_duty[i]),
            .pwm  (PWM_OUT[i])
        );
    end

    assign TCR      = tcr;
    assign E        = e;
    assign LOAD_ACK = load_ack;
endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch: load timing, edge/center counting, prescale,
// stop/resume, shadow reload and reset discarding a pending load.

module tb_pwm_multi_ch;
    localparam int W = 8;
    localparam int C = 4;
    localparam int P = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, en, center, load_req;
    logic [P-1:0] prescale;
    logic [W-1:0] period;
    logic [C*W-1:0] duty;
    logic         load_ack, e;
    logic [W-1:0] tcr;
    logic [C-1:0] pwm;

    int total = 0;
    int bad   = 0;

    pwm_multi_ch #(.WIDTH(W), .CHANNELS(C), .PRESCALE_W(P)) dut (
        .CLK_100MHz (clk),
        .RST        (rst),
        .EN         (en),
        .PRESCALE   (prescale),
        .PERIOD     (period),
        .CENTER     (center),
        .DUTY       (duty),
        .LOAD_REQ   (load_req),
        .LOAD_ACK   (load_ack),
        .E          (e),
        .TCR        (tcr),
        .PWM_OUT    (pwm)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] per, input logic cen, input logic [C*W-1:0] dty);
        period   = per;
        center   = cen;
        duty     = dty;
        load_req = 1'b1;
        cyc();
        load_req = 1'b0;
    endtask

    function automatic int ctr(input int k);
        int m;
        m = k % 8;
        return (m <= 4) ? m : 8 - m;
    endfunction

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; load_req = 1'b1; prescale = '0;
        period = 8'd9; center = 1'b0; duty = {8'd255, 8'd10, 8'd0, 8'd3};
        cyc(); cyc();
        total++; if (tcr !== 8'd0) begin bad++; $display("FAIL reset_tcr got=%0d exp=0", tcr); end
        total++; if (pwm !== 4'b0) begin bad++; $display("FAIL reset_pwm got=%b exp=0000", pwm); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL reset_e got=%b exp=0", e); end
        total++; if (load_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", load_ack); end
        rst = 1'b0; load_req = 1'b0; en = 1'b0;
        cyc();
        total++; if (load_ack !== 1'b0) begin bad++; $display("FAIL reset_override_ack got=%b exp=0", load_ack); end
    endtask

    task automatic test_load_idle;
        do_load(8'd9, 1'b0, {8'd255, 8'd10, 8'd0, 8'd3});
        total++; if (load_ack !== 1'b0) begin bad++; $display("FAIL idle_ack_early got=%b exp=0", load_ack); end
        cyc();
        total++; if (load_ack !== 1'b1) begin bad++; $display("FAIL idle_ack got=%b exp=1", load_ack); end
        cyc();
        total++; if (load_ack !== 1'b0) begin bad++; $display("FAIL idle_ack_pulse got=%b exp=0", load_ack); end
        total++; if (tcr !== 8'd0) begin bad++; $display("FAIL idle_tcr_hold got=%0d exp=0", tcr); end
    endtask

    task automatic test_edge;
        logic [C-1:0] xp;
        int highs;
        highs = 0;
        en = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            xp = 4'b1100 | ((((k - 1) % 10) < 3) ? 4'b0001 : 4'b0000);
            if (pwm[0]) highs++;
            total++; if (tcr !== W'(k % 10)) begin bad++; $display("FAIL edge_tcr k=%0d got=%0d exp=%0d", k, tcr, k % 10); end
            total++; if (e !== (k % 10 == 0)) begin bad++; $display("FAIL edge_e k=%0d got=%b", k, e); end
            total++; if (pwm !== xp) begin bad++; $display("FAIL edge_pwm k=%0d got=%b exp=%b", k, pwm, xp); end
        end
        total++; if (highs != 9) begin bad++; $display("FAIL edge_high_count got=%0d exp=9", highs); end
    endtask

    task automatic test_reload;
        int d;
        for (int k = 31; k <= 50; k++) begin
            cyc();
            if (k == 35) load_req = 1'b0;
            d = (k >= 41) ? 7 : 3;
            total++; if (tcr !== W'(k % 10)) begin bad++; $display("FAIL reload_tcr k=%0d got=%0d exp=%0d", k, tcr, k % 10); end
            total++; if (e !== (k % 10 == 0)) begin bad++; $display("FAIL reload_e k=%0d got=%b", k, e); end
            total++; if (load_ack !== (k == 40)) begin bad++; $display("FAIL reload_ack k=%0d got=%b", k, load_ack); end
            total++; if (pwm[0] !== (((k - 1) % 10) < d)) begin bad++; $display("FAIL reload_pwm0 k=%0d got=%b", k, pwm[0]); end
            if (k == 34) begin
                duty = {8'd255, 8'd10, 8'd0, 8'd7};
                load_req = 1'b1;
            end
        end
    endtask

    task automatic test_center;
        logic [C-1:0] xp;
        rst = 1'b1; en = 1'b0;
        cyc();
        rst = 1'b0;
        do_load(8'd4, 1'b1, {8'd255, 8'd10, 8'd0, 8'd2});
        cyc();
        total++; if (load_ack !== 1'b1) begin bad++; $display("FAIL center_ack got=%b exp=1", load_ack); end
        en = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            cyc();
            xp = 4'b1100 | ((ctr(k - 1) < 2) ? 4'b0001 : 4'b0000);
            total++; if (tcr !== W'(ctr(k))) begin bad++; $display("FAIL center_tcr k=%0d got=%0d exp=%0d", k, tcr, ctr(k)); end
            total++; if (e !== (k % 8 == 0)) begin bad++; $display("FAIL center_e k=%0d got=%b", k, e); end
            total++; if (pwm !== xp) begin bad++; $display("FAIL center_pwm k=%0d got=%b exp=%b", k, pwm, xp); end
        end
    endtask

    task automatic test_hold;
        cyc(); cyc();
        total++; if (tcr !== 8'd2) begin bad++; $display("FAIL hold_pre_tcr got=%0d exp=2", tcr); end
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            total++; if (tcr !== 8'd2) begin bad++; $display("FAIL hold_tcr got=%0d exp=2", tcr); end
            total++; if (pwm !== 4'b0) begin bad++; $display("FAIL hold_pwm got=%b exp=0000", pwm); end
            total++; if (e !== 1'b0) begin bad++; $display("FAIL hold_e got=%b exp=0", e); end
        end
        en = 1'b1;
        cyc();
        total++; if (tcr !== 8'd3) begin bad++; $display("FAIL resume_tcr1 got=%0d exp=3", tcr); end
        cyc();
        total++; if (tcr !== 8'd4) begin bad++; $display("FAIL resume_tcr2 got=%0d exp=4", tcr); end
        cyc();
        total++; if (tcr !== 8'd3) begin bad++; $display("FAIL resume_dir got=%0d exp=3", tcr); end
    endtask

    task automatic test_prescale;
        rst = 1'b1; en = 1'b0;
        cyc();
        rst = 1'b0; prescale = 12'd3;
        do_load(8'd9, 1'b0, {8'd255, 8'd10, 8'd0, 8'd3});
        cyc();
        en = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            cyc();
            total++; if (tcr !== W'((k / 4) % 10)) begin bad++; $display("FAIL psc_tcr k=%0d got=%0d exp=%0d", k, tcr, (k / 4) % 10); end
            total++; if (e !== (k % 40 == 0)) begin bad++; $display("FAIL psc_e k=%0d got=%b", k, e); end
        end
    endtask

    task automatic test_rst_pending;
        rst = 1'b1; en = 1'b0;
        cyc();
        rst = 1'b0; prescale = '0;
        do_load(8'd9, 1'b0, {8'd255, 8'd10, 8'd0, 8'd3});
        cyc();
        en = 1'b1;
        cyc(); cyc(); cyc();
        total++; if (tcr !== 8'd3) begin bad++; $display("FAIL rstp_pre_tcr got=%0d exp=3", tcr); end
        duty = {8'd255, 8'd10, 8'd0, 8'd7};
        load_req = 1'b1;
        cyc();
        load_req = 1'b0;
        rst = 1'b1;
        cyc();
        total++; if (tcr !== 8'd0) begin bad++; $display("FAIL rstp_tcr got=%0d exp=0", tcr); end
        total++; if (pwm !== 4'b0) begin bad++; $display("FAIL rstp_pwm got=%b exp=0000", pwm); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL rstp_e got=%b exp=0", e); end
        total++; if (load_ack !== 1'b0) begin bad++; $display("FAIL rstp_ack got=%b exp=0", load_ack); end
        rst = 1'b0;
        // Active registers are cleared, so PERIOD=0: TCR pinned at 0 and every tick is a boundary.
        for (int k = 1; k <= 25; k++) begin
            cyc();
            total++; if (load_ack !== 1'b0) begin bad++; $display("FAIL rstp_late_ack k=%0d got=%b exp=0", k, load_ack); end
            total++; if (tcr !== 8'd0) begin bad++; $display("FAIL rstp_p0_tcr k=%0d got=%0d exp=0", k, tcr); end
            total++; if (e !== 1'b1) begin bad++; $display("FAIL rstp_p0_e k=%0d got=%b exp=1", k, e); end
            total++; if (pwm !== 4'b0) begin bad++; $display("FAIL rstp_p0_pwm k=%0d got=%b exp=0000", k, pwm); end
        end
    endtask

    initial begin
        test_reset();
        test_load_idle();
        test_edge();
        test_reload();
        test_center();
        test_hold();
        test_prescale();
        test_rst_pending();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
